uart_tx_frame: RTL and testbench

//  UART transmitter; the transmit-side counterpart of the UART_RX receive path.

---
 rtl/uart_tx_frame.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmitter. A parallel word is accepted on a one-cycle request while
//   idle and is sent on the serial line as: start (0), DATA_WIDTH data bits
//   LSB first, an optional parity bit, and stop (1). Each bit is held for
//   CLKS_PER_BIT clock cycles. The line idles high.
//
// Ports
//   CLK         in   single clock, all logic on its rising edge
//   RST         in   synchronous reset, active low
//   P_DATA      in   parallel word to send
//   Data_Valid  in   request; P_DATA/PAR_EN/PAR_TYP are sampled when accepted
//   PAR_EN      in   1 = append a parity bit after the data bits
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   TX_OUT      out  serial line (registered)
//   Busy        out  high for the whole frame (registered)
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  load;
  logic                  bit_end;
  logic                  parity_bit;
  logic                  tx_nxt;
  logic                  busy_nxt;

  assign load       = (state == IDLE) && Data_Valid;
  assign bit_end    = (cnt == CNT_MAX);
  // Odd parity is the inverse of even parity over the latched word.
  assign parity_bit = (^data_q) ^ par_typ_q;

  // State register plus the registered outputs. The frame parameters are
  // captured only on acceptance so later input changes cannot disturb a frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      TX_OUT <= tx_nxt;
      Busy   <= busy_nxt;
      if (load) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  // Next-state logic. The cycle counter restarts at every bit boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (Data_Valid) state_nxt = START;
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (idx == IDX_MAX) begin
            state_nxt = par_en_q ? PARITY : STOP;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Output logic is decoded from the next state so the registered outputs
  // change on the same edge as the state, giving one-cycle request latency.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b0;
    case (state_nxt)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
      START: begin
        tx_nxt   = 1'b0;
        busy_nxt = 1'b1;
      end
      DATA: begin
        tx_nxt   = data_q[idx_nxt];
        busy_nxt = 1'b1;
      end
      PARITY: begin
        tx_nxt   = parity_bit;
        busy_nxt = 1'b1;
      end
      STOP: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b1;
      end
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Bench for uart_tx_frame. Two instances: one at one clock per bit, one at
//   four clocks per bit. Expected frames are written as hand-computed bit
//   strings in transmission order (leftmost bit goes out first) and queued as
//   each request is issued; a monitor per instance rebuilds every frame from
//   the line while Busy is high and compares it against the queue.
module tb_uart_tx_frame;

  typedef struct {
    int          id;
    logic [63:0] bits;
    int          len;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       dv1 = 1'b0;
  logic       dv4 = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       tx1;
  logic       busy1;
  logic       tx4;
  logic       busy4;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     last_gap[2];
  bit     mon_en = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(dv1),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx1), .Busy(busy1)
  );

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(dv4),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx4), .Busy(busy4)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic busy_of(input int id);
    return (id == 0) ? busy1 : busy4;
  endfunction

  task automatic expect_frame(input int id, input logic [63:0] bits, input int len);
    frame_t f;
    f.id   = id;
    f.bits = bits;
    f.len  = len;
    exp_q.push_back(f);
  endtask

  // One-cycle request, driven 1 time unit after the edge.
  task automatic send(input int id, input logic [7:0] d, input logic pen, input logic ptyp);
    P_DATA  = d;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    if (id == 0) dv1 = 1'b1; else dv4 = 1'b1;
    @(posedge CLK);
    #1;
    dv1 = 1'b0;
    dv4 = 1'b0;
  endtask

  task automatic wait_busy(input int id, input logic level, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (busy_of(id) == level) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int id, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0 && !busy_of(id)) done = 1'b1;
    end
    if (!done) chk({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic monitor(input int id);
    logic [63:0] got = '0;
    int          len = 0;
    int          idle = 0;
    logic        tx;
    logic        bz;
    frame_t      e;
    forever begin
      @(negedge CLK);
      tx = (id == 0) ? tx1 : tx4;
      bz = (id == 0) ? busy1 : busy4;
      if (!RST || !mon_en) begin
        // An aborted frame is discarded; it is never expected to complete.
        got = '0;
        len = 0;
      end else if (bz) begin
        if (len == 0) begin
          last_gap[id] = idle;
          idle = 0;
        end
        got = {got[62:0], tx};
        len++;
      end else begin
        idle++;
        chk($sformatf("idle_line_%0d", id), 64'(tx), 64'd1);
        if (len > 0) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_frame_%0d", id), got, 64'd0);
            checks--;
            errors += (got == 64'd0) ? 1 : 0;
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("frame_id_%0d", id), 64'(id), 64'(e.id));
            chk($sformatf("frame_len_%0d", id), 64'(len), 64'(e.len));
            chk($sformatf("frame_bits_%0d", id), got, e.bits);
          end
          got = '0;
          len = 0;
        end
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tx1", 64'(tx1), 64'd1);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_tx4", 64'(tx4), 64'd1);
    chk("rst_busy4", 64'(busy4), 64'd0);
    RST = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // A5, even parity: parity 0
    expect_frame(0, 64'(11'b0_10100101_0_1), 11);
    send(0, 8'hA5, 1'b1, 1'b0);
    chk("latency_tx", 64'(tx1), 64'd0);
    chk("latency_busy", 64'(busy1), 64'd1);
    wait_done(0, "t1");

    // A5, odd parity: parity 1
    expect_frame(0, 64'(11'b0_10100101_1_1), 11);
    send(0, 8'hA5, 1'b1, 1'b1);
    wait_done(0, "t2a");

    // A5, no parity slot
    expect_frame(0, 64'(10'b0_10100101_1), 10);
    send(0, 8'hA5, 1'b0, 1'b0);
    wait_done(0, "t2b");

    // Mid-frame request and input changes are ignored
    expect_frame(0, 64'(11'b0_10100101_0_1), 11);
    send(0, 8'hA5, 1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    send(0, 8'h3C, 1'b0, 1'b1);
    P_DATA = 8'hFF;
    wait_done(0, "t3");
    repeat (15) @(posedge CLK);
    #1;
    chk("t3_no_second_frame", 64'(busy1), 64'd0);

    // Data_Valid held high: two back-to-back frames with one idle cycle
    expect_frame(0, 64'(10'b0_10000000_1), 10);
    expect_frame(0, 64'(10'b0_01000000_1), 10);
    P_DATA  = 8'h01;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    dv1     = 1'b1;
    @(posedge CLK);
    #1;
    P_DATA = 8'h02;
    wait_busy(0, 1'b0, "t4_fall");
    @(posedge CLK);
    #1;
    chk("t4_second_start", 64'(busy1), 64'd1);
    dv1 = 1'b0;
    @(negedge CLK);
    #1;
    chk("t4_gap", 64'(last_gap[0]), 64'd1);
    wait_done(0, "t4");

    // Four clocks per bit, all-zero word: 36 low cycles then 4 high
    expect_frame(1, 64'hF, 40);
    send(1, 8'h00, 1'b0, 1'b0);
    wait_done(1, "t5");

    // Reset during data bit 3 aborts the frame
    send(0, 8'hA5, 1'b1, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_tx", 64'(tx1), 64'd1);
    chk("abort_busy", 64'(busy1), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (15) @(posedge CLK);
    #1;
    chk("post_rst_tx", 64'(tx1), 64'd1);
    chk("post_rst_busy", 64'(busy1), 64'd0);
    expect_frame(0, 64'(11'b0_00111100_0_1), 11);
    send(0, 8'h3C, 1'b1, 1'b0);
    wait_done(0, "t6");

    repeat (20) @(posedge CLK);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
